fifo_ram_controller: RTL

//  Sequencing controller that turns a 32x8 single-port, level-strobed RAM into a synchronous FIFO.

---
 rtl/fifo_ram_pkg.sv | 22 ++
 rtl/fifo_rr_arbiter.sv | 21 ++
 rtl/fifo_ram_controller.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/fifo_ram_pkg.sv
// Shared widths and encodings for the RAM-backed FIFO controller.
package fifo_ram_pkg;

    localparam int unsigned FIFO_DATA_WIDTH = 8;
    localparam int unsigned FIFO_ADDR_WIDTH = 5;
    localparam int unsigned FIFO_DEPTH      = 2 ** FIFO_ADDR_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WR_SETUP  = 3'd1,
        ST_WR_STROBE = 3'd2,
        ST_WR_HOLD   = 3'd3,
        ST_RD_SETUP  = 3'd4,
        ST_RD_SAMPLE = 3'd5
    } state_t;

    typedef enum logic {
        OP_POP  = 1'b0,
        OP_PUSH = 1'b1
    } op_t;

endpackage

// File: rtl/fifo_rr_arbiter.sv
// Two-way round-robin between eligible push and pop requests.
module fifo_rr_arbiter
    import fifo_ram_pkg::*;
(
    input  logic push_elig_i,
    input  logic pop_elig_i,
    input  op_t  last_op_i,
    output logic grant_push_o,
    output logic grant_pop_o
);

    logic prefer_push;

    // On a tie, serve whichever operation did not go last.
    always_comb begin
        prefer_push  = (last_op_i == OP_POP);
        grant_push_o = push_elig_i & (~pop_elig_i | prefer_push);
        grant_pop_o  = pop_elig_i & (~push_elig_i | ~prefer_push);
    end

endmodule

// File: rtl/fifo_ram_controller.sv
// Sequences a single-port level-strobed RAM as a synchronous FIFO.
// Acks are same-cycle handshakes; every RAM-side pin comes from a flop.
module fifo_ram_controller
    import fifo_ram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = FIFO_ADDR_WIDTH
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Push,
    input  logic [DATA_WIDTH-1:0] Push_Data,
    output logic                  Push_Ack,
    input  logic                  Pop,
    output logic                  Pop_Ack,
    output logic [DATA_WIDTH-1:0] Read_Data,
    output logic                  Read_Valid,
    output logic                  Full,
    output logic                  Empty,
    output logic [ADDR_WIDTH:0]   Count,
    output logic [ADDR_WIDTH-1:0] Ram_Address,
    output logic [DATA_WIDTH-1:0] Ram_Data,
    output logic                  Ram_Write_Enable,
    output logic                  Ram_Chip_Select,
    input  logic [DATA_WIDTH-1:0] Ram_Output
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    state_t                state_q;
    op_t                   last_op_q;
    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [ADDR_WIDTH-1:0] rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic                  full_q;
    logic                  empty_q;
    logic [DATA_WIDTH-1:0] read_data_q;
    logic                  read_valid_q;
    logic [ADDR_WIDTH-1:0] ram_addr_q;
    logic [DATA_WIDTH-1:0] ram_data_q;
    logic                  ram_we_q;
    logic                  ram_cs_q;

    logic in_idle_c;
    logic grant_push_c;
    logic grant_pop_c;

    assign in_idle_c = (state_q == ST_IDLE);

    fifo_rr_arbiter u_arb (
        .push_elig_i  (in_idle_c & Push & ~full_q),
        .pop_elig_i   (in_idle_c & Pop & ~empty_q),
        .last_op_i    (last_op_q),
        .grant_push_o (grant_push_c),
        .grant_pop_o  (grant_pop_c)
    );

    // Request is accepted in the IDLE cycle it is sampled; no ack while in reset.
    assign Push_Ack = grant_push_c & ~Reset;
    assign Pop_Ack  = grant_pop_c & ~Reset;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            last_op_q    <= OP_POP;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            ram_addr_q   <= '0;
            ram_data_q   <= '0;
            ram_we_q     <= 1'b0;
            ram_cs_q     <= 1'b0;
        end else begin
            read_valid_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    ram_cs_q <= 1'b0;
                    ram_we_q <= 1'b0;
                    if (grant_push_c) begin
                        ram_data_q <= Push_Data;
                        ram_addr_q <= wr_ptr_q;
                        last_op_q  <= OP_PUSH;
                        state_q    <= ST_WR_SETUP;
                    end else if (grant_pop_c) begin
                        ram_addr_q <= rd_ptr_q;
                        last_op_q  <= OP_POP;
                        state_q    <= ST_RD_SETUP;
                    end
                end
                // Flops load the strobe one cycle ahead so it lands in WR_STROBE.
                ST_WR_SETUP: begin
                    ram_cs_q <= 1'b1;
                    ram_we_q <= 1'b1;
                    state_q  <= ST_WR_STROBE;
                end
                ST_WR_STROBE: begin
                    ram_cs_q <= 1'b0;
                    ram_we_q <= 1'b0;
                    state_q  <= ST_WR_HOLD;
                end
                ST_WR_HOLD: begin
                    wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
                    count_q  <= count_q + CNT_W'(1);
                    full_q   <= (count_q == CNT_W'(DEPTH - 1));
                    empty_q  <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                ST_RD_SETUP: begin
                    ram_cs_q <= 1'b1;
                    ram_we_q <= 1'b0;
                    state_q  <= ST_RD_SAMPLE;
                end
                // Bus is only driven here, so this is the one place it is sampled.
                ST_RD_SAMPLE: begin
                    ram_cs_q     <= 1'b0;
                    read_data_q  <= Ram_Output;
                    read_valid_q <= 1'b1;
                    rd_ptr_q     <= rd_ptr_q + ADDR_WIDTH'(1);
                    count_q      <= count_q - CNT_W'(1);
                    empty_q      <= (count_q == CNT_W'(1));
                    full_q       <= 1'b0;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    ram_cs_q <= 1'b0;
                    ram_we_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

    assign Read_Data        = read_data_q;
    assign Read_Valid       = read_valid_q;
    assign Full             = full_q;
    assign Empty            = empty_q;
    assign Count            = count_q;
    assign Ram_Address      = ram_addr_q;
    assign Ram_Data         = ram_data_q;
    assign Ram_Write_Enable = ram_we_q;
    assign Ram_Chip_Select  = ram_cs_q;

endmodule
